// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types for the CPU/DMA main-memory bus arbiter: FSM encodings, master IDs,
// the muxed request bundle and the round-robin pick used in IDLE.
package mem_bus_arbiter_pkg;

    localparam int CNT_W = 8;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'b00,
        ARB_GNT_CPU = 2'b01,
        ARB_GNT_DMA = 2'b10,
        ARB_PARK    = 2'b11
    } arb_state_t;

    typedef enum logic {
        MST_CPU = 1'b0,
        MST_DMA = 1'b1
    } mst_id_t;

    typedef struct packed {
        logic        cyc;
        logic        we;
        logic [3:0]  strb;
        logic [31:0] addr;
        logic [31:0] dat;
    } req_t;

    // With both masters requesting, the one not served last wins.
    function automatic mst_id_t rr_pick(input logic cpu_cyc, input logic dma_cyc, input mst_id_t last);
        if (cpu_cyc && dma_cyc) begin
            return (last == MST_CPU) ? MST_DMA : MST_CPU;
        end
        return dma_cyc ? MST_DMA : MST_CPU;
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Signal bundle between the CPU master, DMA master, memory slave and the arbiter.
// master: arbiter view (it drives the shared slave bus); slave: environment view.
interface mem_bus_arbiter_if;

    logic        cpu_cyc;
    logic        cpu_we;
    logic [3:0]  cpu_strb;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_data_o;
    logic        cpu_ack;
    logic        cpu_err;
    logic [31:0] cpu_data_i;

    logic        dma_cyc;
    logic        dma_we;
    logic [3:0]  dma_strb;
    logic [31:0] dma_addr;
    logic [31:0] dma_data_o;
    logic        dma_ack;
    logic        dma_err;
    logic [31:0] dma_data_i;

    logic        s_cyc;
    logic        s_we;
    logic [3:0]  s_strb;
    logic [31:0] s_addr;
    logic [31:0] s_data_o;
    logic        s_ack;
    logic [31:0] s_data_i;

    logic        gnt_cpu;
    logic        gnt_dma;

    modport master (
        input  cpu_cyc, cpu_we, cpu_strb, cpu_addr, cpu_data_o,
        input  dma_cyc, dma_we, dma_strb, dma_addr, dma_data_o,
        input  s_ack, s_data_i,
        output cpu_ack, cpu_err, cpu_data_i,
        output dma_ack, dma_err, dma_data_i,
        output s_cyc, s_we, s_strb, s_addr, s_data_o,
        output gnt_cpu, gnt_dma
    );

    modport slave (
        output cpu_cyc, cpu_we, cpu_strb, cpu_addr, cpu_data_o,
        output dma_cyc, dma_we, dma_strb, dma_addr, dma_data_o,
        output s_ack, s_data_i,
        input  cpu_ack, cpu_err, cpu_data_i,
        input  dma_ack, dma_err, dma_data_i,
        input  s_cyc, s_we, s_strb, s_addr, s_data_o,
        input  gnt_cpu, gnt_dma
    );

endinterface

// File: rtl/arb_tenure_cnt.sv
// DMA burst and ack-timeout counters for the current tenure; flags are combinational
// from the counters, both counters clear on reset or when the FSM parks.
module arb_tenure_cnt
    import mem_bus_arbiter_pkg::*;
#(
    parameter int unsigned MAX_DMA_BURST = 16,
    parameter int unsigned TIMEOUT       = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic burst_inc,
    input  logic to_inc,
    input  logic to_clr,
    output logic burst_done,
    output logic timeout
);

    localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(MAX_DMA_BURST - 1);
    localparam logic [CNT_W-1:0] TO_LAST    = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] burst_cnt;
    logic [CNT_W-1:0] to_cnt;

    // burst_cnt saturates so an unopposed DMA can stream forever.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            burst_cnt <= '0;
            to_cnt    <= '0;
        end else begin
            if (burst_inc && (burst_cnt != BURST_LAST)) begin
                burst_cnt <= burst_cnt + 1'b1;
            end
            if (to_clr) begin
                to_cnt <= '0;
            end else if (to_inc && (to_cnt != TO_LAST)) begin
                to_cnt <= to_cnt + 1'b1;
            end
        end
    end

    assign burst_done = (burst_cnt == BURST_LAST);
    assign timeout    = to_inc && (to_cnt == TO_LAST);

endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbitrates the main-memory slave bus between CPU and DMA; grant registers one cycle
// after request, request mux and ack routing are combinational from the grant.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int unsigned MAX_DMA_BURST = 16,
    parameter int unsigned TIMEOUT       = 255
) (
    input  logic              clk,
    input  logic              rst,
    mem_bus_arbiter_if.master bus
);

    arb_state_t state;
    mst_id_t    last;
    mst_id_t    pick;
    logic       gnt_cpu_q;
    logic       gnt_dma_q;
    logic       cpu_err_q;
    logic       dma_err_q;
    logic       burst_done;
    logic       timeout;
    logic       granted_cyc;
    logic       to_inc;
    logic       burst_inc;
    logic       cnt_clr;
    req_t       cpu_req;
    req_t       dma_req;
    req_t       s_req;

    assign cpu_req = '{cyc: bus.cpu_cyc, we: bus.cpu_we, strb: bus.cpu_strb,
                       addr: bus.cpu_addr, dat: bus.cpu_data_o};
    assign dma_req = '{cyc: bus.dma_cyc, we: bus.dma_we, strb: bus.dma_strb,
                       addr: bus.dma_addr, dat: bus.dma_data_o};

    assign pick        = rr_pick(bus.cpu_cyc, bus.dma_cyc, last);
    assign granted_cyc = (gnt_cpu_q & bus.cpu_cyc) | (gnt_dma_q & bus.dma_cyc);
    assign to_inc      = granted_cyc & ~bus.s_ack;
    assign burst_inc   = gnt_dma_q & bus.s_ack;
    assign cnt_clr     = (state == ARB_PARK);

    arb_tenure_cnt #(
        .MAX_DMA_BURST (MAX_DMA_BURST),
        .TIMEOUT       (TIMEOUT)
    ) u_tenure_cnt (
        .clk        (clk),
        .rst        (rst),
        .clr        (cnt_clr),
        .burst_inc  (burst_inc),
        .to_inc     (to_inc),
        .to_clr     (bus.s_ack),
        .burst_done (burst_done),
        .timeout    (timeout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ARB_IDLE;
            last      <= MST_CPU;
            gnt_cpu_q <= 1'b0;
            gnt_dma_q <= 1'b0;
            cpu_err_q <= 1'b0;
            dma_err_q <= 1'b0;
        end else begin
            cpu_err_q <= 1'b0;
            dma_err_q <= 1'b0;
            case (state)
                ARB_IDLE: begin
                    if (bus.cpu_cyc || bus.dma_cyc) begin
                        if (pick == MST_DMA) begin
                            state     <= ARB_GNT_DMA;
                            gnt_dma_q <= 1'b1;
                        end else begin
                            state     <= ARB_GNT_CPU;
                            gnt_cpu_q <= 1'b1;
                        end
                    end
                end
                ARB_GNT_CPU: begin
                    if (timeout || !bus.cpu_cyc) begin
                        cpu_err_q <= timeout;
                        gnt_cpu_q <= 1'b0;
                        last      <= MST_CPU;
                        state     <= ARB_PARK;
                    end
                end
                ARB_GNT_DMA: begin
                    // Forced yield only on the ack that completes the last burst slot.
                    if (timeout || !bus.dma_cyc ||
                        (burst_done && bus.s_ack && bus.cpu_cyc)) begin
                        dma_err_q <= timeout;
                        gnt_dma_q <= 1'b0;
                        last      <= MST_DMA;
                        state     <= ARB_PARK;
                    end
                end
                ARB_PARK: begin
                    state <= ARB_IDLE;
                end
                default: begin
                    state <= ARB_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        s_req = '0;
        if (!rst) begin
            if (gnt_cpu_q) begin
                s_req = cpu_req;
            end else if (gnt_dma_q) begin
                s_req = dma_req;
            end
        end
    end

    assign bus.s_cyc      = s_req.cyc;
    assign bus.s_we       = s_req.we;
    assign bus.s_strb     = s_req.strb;
    assign bus.s_addr     = s_req.addr;
    assign bus.s_data_o   = s_req.dat;

    assign bus.gnt_cpu    = ~rst & gnt_cpu_q;
    assign bus.gnt_dma    = ~rst & gnt_dma_q;
    assign bus.cpu_ack    = ~rst & gnt_cpu_q & bus.s_ack;
    assign bus.dma_ack    = ~rst & gnt_dma_q & bus.s_ack;
    assign bus.cpu_err    = ~rst & cpu_err_q;
    assign bus.dma_err    = ~rst & dma_err_q;
    assign bus.cpu_data_i = (~rst & gnt_cpu_q) ? bus.s_data_i : '0;
    assign bus.dma_data_i = (~rst & gnt_dma_q) ? bus.s_data_i : '0;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: stimulus queues expected slave-bus responses,
// a negedge monitor pops and compares every ack/err the DUT routes to a master.
module tb_mem_bus_arbiter;
    import mem_bus_arbiter_pkg::*;

    localparam logic [31:0] RD_KEY = 32'h5A5A_0000;

    typedef enum int {K_CPU_ACK, K_DMA_ACK, K_CPU_ERR, K_DMA_ERR} kind_t;
    typedef struct {
        kind_t       kind;
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
    } exp_t;

    logic  clk = 1'b0;
    logic  rst = 1'b1;
    int    n_checks = 0;
    int    n_fail = 0;
    exp_t  exp_q[$];
    int    ack_delay = 0;
    bit    ack_en = 1'b1;
    bit    stray_ack = 1'b0;
    int    slv_wait = 0;
    int    dma_gnt_rises = 0;

    mem_bus_arbiter_if bus();

    mem_bus_arbiter #(
        .MAX_DMA_BURST (16),
        .TIMEOUT       (255)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic bound_fail(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: wait bound expired, got no response, required one", name);
    endtask

    function automatic void push_exp(input kind_t k, input logic [31:0] a, input logic we,
                                     input logic [31:0] wd);
        exp_t e;
        e.kind  = k;
        e.addr  = a;
        e.we    = we;
        e.wdata = wd;
        exp_q.push_back(e);
    endfunction

    function automatic void push_dma(input logic [31:0] base, input int first, input int count);
        logic [31:0] a;
        for (int i = first; i < first + count; i++) begin
            a = base + 32'(4 * i);
            push_exp(K_DMA_ACK, a, 1'b1, ~a);
        end
    endfunction

    // Memory slave: acks ack_delay cycles after s_cyc is seen, data is a function of address.
    initial begin : slave_model
        bus.s_ack    = 1'b0;
        bus.s_data_i = '0;
        forever begin
            @(posedge clk);
            #2;
            if (bus.s_cyc && ack_en && slv_wait == ack_delay) begin
                bus.s_ack = 1'b1;
                slv_wait  = 0;
            end else begin
                bus.s_ack = stray_ack;
                slv_wait  = bus.s_cyc ? slv_wait + 1 : 0;
            end
            bus.s_data_i = bus.s_addr ^ RD_KEY;
        end
    end

    initial begin : monitor
        kind_t       k;
        exp_t        e;
        logic [31:0] routed;
        logic [31:0] other;
        logic        prev_gnt_dma;
        prev_gnt_dma = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.gnt_dma && !prev_gnt_dma) dma_gnt_rises++;
            prev_gnt_dma = bus.gnt_dma;
            if (!rst && (bus.cpu_ack || bus.dma_ack || bus.cpu_err || bus.dma_err)) begin
                k      = bus.cpu_ack ? K_CPU_ACK : bus.dma_ack ? K_DMA_ACK :
                         bus.cpu_err ? K_CPU_ERR : K_DMA_ERR;
                routed = (k == K_CPU_ACK) ? bus.cpu_data_i : bus.dma_data_i;
                other  = (k == K_CPU_ACK) ? bus.dma_data_i : bus.cpu_data_i;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL sb_unexpected: got response kind %0d at s_addr %h, required none",
                             k, bus.s_addr);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_kind", 32'(k), 32'(e.kind));
                    if (k == K_CPU_ACK || k == K_DMA_ACK) begin
                        check("sb_addr", bus.s_addr, e.addr);
                        check("sb_we", 32'(bus.s_we), 32'(e.we));
                        check("sb_wdata", bus.s_data_o, e.wdata);
                        check("sb_rdata", routed, e.addr ^ RD_KEY);
                        check("sb_other_data", other, 32'd0);
                    end
                end
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        bus.cpu_cyc = 1'b0; bus.cpu_we = 1'b0; bus.cpu_strb = 4'h0;
        bus.cpu_addr = '0;  bus.cpu_data_o = '0;
        bus.dma_cyc = 1'b0; bus.dma_we = 1'b0; bus.dma_strb = 4'h0;
        bus.dma_addr = '0;  bus.dma_data_o = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_outputs", 32'({bus.gnt_cpu, bus.gnt_dma, bus.s_cyc, bus.cpu_ack,
                                  bus.dma_ack, bus.cpu_err, bus.dma_err}), 32'd0);
        check("rst_state", 32'(dut.state), 32'(ARB_IDLE));
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic cpu_xfer(input logic [31:0] addr);
        int budget;
        budget = 600;
        bus.cpu_cyc = 1'b1; bus.cpu_we = 1'b0; bus.cpu_strb = 4'hF;
        bus.cpu_addr = addr; bus.cpu_data_o = '0;
        while (!bus.cpu_ack && !bus.cpu_err && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (!bus.cpu_ack && !bus.cpu_err) bound_fail("cpu_xfer");
        @(posedge clk);
        #1;
        bus.cpu_cyc = 1'b0;
        bus.cpu_addr = '0;
    endtask

    task automatic dma_stream(input int n, input logic [31:0] base);
        int i;
        int budget;
        i = 0;
        budget = 2000;
        bus.dma_cyc = 1'b1; bus.dma_we = 1'b1; bus.dma_strb = 4'hF;
        bus.dma_addr = base; bus.dma_data_o = ~base;
        while (i < n && budget > 0) begin
            @(negedge clk);
            budget--;
            if (bus.dma_ack) begin
                i++;
                @(posedge clk);
                #1;
                bus.dma_addr   = base + 32'(4 * i);
                bus.dma_data_o = ~bus.dma_addr;
            end
        end
        if (i < n) bound_fail("dma_stream");
        bus.dma_cyc = 1'b0;
    endtask

    initial begin : stimulus
        int n;
        do_reset();

        // 1: lone CPU read, slave acks in the 3rd grant cycle; stray acks in PARK/IDLE ignored
        ack_delay = 2;
        push_exp(K_CPU_ACK, 32'h100, 1'b0, 32'h0);
        @(posedge clk); #1;
        bus.cpu_cyc = 1'b1; bus.cpu_we = 1'b0; bus.cpu_strb = 4'hF;
        bus.cpu_addr = 32'h100; bus.cpu_data_o = '0;
        @(negedge clk);
        check("t1_gnt_before_edge", 32'(bus.gnt_cpu), 32'd0);
        @(negedge clk);
        check("t1_gnt_latency", 32'(bus.gnt_cpu), 32'd1);
        check("t1_s_addr", bus.s_addr, 32'h100);
        n = 0;
        while (!bus.cpu_ack && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("t1_ack_cycle", 32'(n), 32'd2);
        @(posedge clk); #1;
        bus.cpu_cyc = 1'b0;
        @(negedge clk);
        stray_ack = 1'b1;
        @(negedge clk);
        check("t1_park_state", 32'(dut.state), 32'(ARB_PARK));
        check("t1_park_gnt", 32'({bus.gnt_cpu, bus.gnt_dma, bus.s_cyc}), 32'd0);
        check("t1_park_stray_ack", 32'({bus.cpu_ack, bus.dma_ack}), 32'd0);
        @(negedge clk);
        check("t1_idle_state", 32'(dut.state), 32'(ARB_IDLE));
        check("t1_idle_stray_ack", 32'({bus.cpu_ack, bus.dma_ack}), 32'd0);
        stray_ack = 1'b0;
        repeat (2) @(negedge clk);

        // 2: simultaneous requests after reset, DMA wins because last=CPU
        do_reset();
        ack_delay = 1;
        push_dma(32'h1000, 0, 2);
        push_exp(K_CPU_ACK, 32'h200, 1'b0, 32'h0);
        @(posedge clk); #1;
        fork
            dma_stream(2, 32'h1000);
            cpu_xfer(32'h200);
            begin
                repeat (2) @(negedge clk);
                check("t2_first_gnt", 32'({bus.gnt_cpu, bus.gnt_dma}), 32'b01);
            end
        join
        repeat (4) @(negedge clk);
        check("t2_drained", 32'(exp_q.size()), 32'd0);

        // 3: 40-word DMA stream, CPU request during the burst forces a yield after 16 acks
        ack_delay = 0;
        dma_gnt_rises = 0;
        push_dma(32'h2000, 0, 16);
        push_exp(K_CPU_ACK, 32'h300, 1'b0, 32'h0);
        push_dma(32'h2000, 16, 24);
        fork
            dma_stream(40, 32'h2000);
            begin
                repeat (6) @(posedge clk);
                #1;
                cpu_xfer(32'h300);
            end
        join
        repeat (4) @(negedge clk);
        check("t3_dma_grants", 32'(dma_gnt_rises), 32'd2);
        check("t3_drained", 32'(exp_q.size()), 32'd0);

        // 4: same stream with CPU idle stays under one grant
        dma_gnt_rises = 0;
        push_dma(32'h4000, 0, 40);
        @(posedge clk); #1;
        dma_stream(40, 32'h4000);
        repeat (4) @(negedge clk);
        check("t4_dma_grants", 32'(dma_gnt_rises), 32'd1);
        check("t4_drained", 32'(exp_q.size()), 32'd0);

        // 5: slave never acks, CPU gets a single err pulse 255 cycles after grant
        ack_en = 1'b0;
        push_exp(K_CPU_ERR, 32'h500, 1'b0, 32'h0);
        @(posedge clk); #1;
        fork
            cpu_xfer(32'h500);
            begin
                n = 0;
                while (!bus.gnt_cpu && n < 10) begin
                    @(negedge clk);
                    n++;
                end
                n = 0;
                while (!bus.cpu_err && n < 400) begin
                    @(negedge clk);
                    n++;
                end
                check("t5_err_latency", 32'(n), 32'd255);
                check("t5_err_gnt", 32'(bus.gnt_cpu), 32'd0);
                @(negedge clk);
                check("t5_err_pulse", 32'(bus.cpu_err), 32'd0);
                check("t5_idle_state", 32'(dut.state), 32'(ARB_IDLE));
            end
        join
        repeat (3) @(negedge clk);
        check("t5_drained", 32'(exp_q.size()), 32'd0);

        // 6: reset mid DMA tenure drops the grant; arbitration restarts with last=CPU
        @(posedge clk); #1;
        bus.dma_cyc = 1'b1; bus.dma_we = 1'b1; bus.dma_strb = 4'hF;
        bus.dma_addr = 32'h6000; bus.dma_data_o = 32'h1234_5678;
        repeat (3) @(negedge clk);
        check("t6_pre_gnt", 32'(bus.gnt_dma), 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        bus.cpu_cyc = 1'b1; bus.cpu_addr = 32'h600;
        @(posedge clk); #1;
        check("t6_rst_drop", 32'({bus.gnt_dma, bus.s_cyc}), 32'd0);
        check("t6_rst_state", 32'(dut.state), 32'(ARB_IDLE));
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("t6_idle_after_rst", 32'({bus.gnt_cpu, bus.gnt_dma}), 32'b00);
        @(negedge clk);
        check("t6_regrant", 32'({bus.gnt_cpu, bus.gnt_dma}), 32'b01);
        @(posedge clk); #1;
        bus.dma_cyc = 1'b0;
        bus.cpu_cyc = 1'b0;
        repeat (4) @(negedge clk);
        check("final_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no end of test, required end");
        $fatal(1, "watchdog expired");
    end

endmodule
